ibex_register_file_banked: RTL and testbench

- Flip-flop RISC-V integer register file with NumBanks selectable register banks, for fast interrupt context switching in the real-time core.
- Provides NumReadPorts combinational read ports, one write port and optional write-to-read bypass.
- A handshaked bank-switch controller and a background bank-clear sequencer move or scrub contexts without stalling the pipeline.
- Sits in the ID stage in place of the single-bank register file.

---
 rtl/ibex_register_file_banked.sv | 162 ++++++++++++++++
 tb/tb_ibex_register_file_banked.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ibex_register_file_banked.sv
// Banked flip-flop register file: the active bank serves the read/write ports, with a handshaked
// bank switch and a background sequencer that scrubs an inactive bank one word per cycle.
module ibex_register_file_banked #(
  parameter bit                   RV32E        = 1'b0,
  parameter int unsigned          DataWidth    = 32,
  parameter int unsigned          NumBanks     = 2,
  parameter int unsigned          NumReadPorts = 2,
  parameter bit                   WriteBypass  = 1'b0,
  parameter logic [DataWidth-1:0] WordZeroVal  = '0,
  localparam int unsigned         BankW        = $clog2(NumBanks)
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic [NumReadPorts*5-1:0]         raddr_i,
  output logic [NumReadPorts*DataWidth-1:0] rdata_o,
  input  logic [4:0]                        waddr_a_i,
  input  logic [DataWidth-1:0]              wdata_a_i,
  input  logic                              we_a_i,
  input  logic                              bank_switch_req_i,
  input  logic [BankW-1:0]                  bank_sel_i,
  output logic                              bank_switch_ack_o,
  output logic [BankW-1:0]                  active_bank_o,
  input  logic                              bank_clr_req_i,
  input  logic [BankW-1:0]                  bank_clr_idx_i,
  output logic                              bank_clr_busy_o,
  output logic                              err_o
);

  localparam int unsigned      AddrW     = RV32E ? 4 : 5;
  localparam int unsigned      NumWords  = 2 ** AddrW;
  localparam logic [BankW:0]   NumBanksW = (BankW + 1)'(NumBanks);
  localparam logic [AddrW-1:0] LastWord  = AddrW'(NumWords - 1);

  typedef enum logic {StIdle, StClear} clr_state_e;

  // Word 0 has no storage in any bank.
  logic [DataWidth-1:0] mem_q [NumBanks][1:NumWords-1];
  logic [DataWidth-1:0] mem_d [NumBanks][1:NumWords-1];

  logic [BankW-1:0] active_bank_q, active_bank_d;
  logic             ack_q, ack_d;
  logic             err_q, err_d;
  clr_state_e       clr_state_q, clr_state_d;
  logic [BankW-1:0] clr_idx_q, clr_idx_d;
  logic [AddrW-1:0] clr_cnt_q, clr_cnt_d;

  logic [AddrW-1:0] waddr;
  logic             we_bad, we_valid;
  logic             sel_valid, clr_idx_valid;
  logic             clr_start, clr_err, clr_busy, sw_blocked;

  assign waddr         = waddr_a_i[AddrW-1:0];
  assign we_bad        = RV32E && we_a_i && waddr_a_i[4];
  assign we_valid      = we_a_i && !we_bad && (waddr != '0);
  assign sel_valid     = {1'b0, bank_sel_i} < NumBanksW;
  assign clr_idx_valid = {1'b0, bank_clr_idx_i} < NumBanksW;

  // Clear sequencer: next-state logic.
  always_comb begin
    clr_state_d = clr_state_q;
    clr_idx_d   = clr_idx_q;
    clr_cnt_d   = clr_cnt_q;
    clr_start   = 1'b0;
    clr_err     = 1'b0;
    unique case (clr_state_q)
      StIdle: begin
        if (bank_clr_req_i) begin
          if (clr_idx_valid && (bank_clr_idx_i != active_bank_q)) begin
            clr_start   = 1'b1;
            clr_state_d = StClear;
            clr_idx_d   = bank_clr_idx_i;
            clr_cnt_d   = AddrW'(1);
          end else begin
            clr_err = 1'b1;
          end
        end
      end
      StClear: begin
        clr_err   = bank_clr_req_i;
        clr_cnt_d = clr_cnt_q + AddrW'(1);
        if (clr_cnt_q == LastWord) begin
          clr_state_d = StIdle;
        end
      end
      default: clr_state_d = StIdle;
    endcase
  end

  // Clear sequencer: outputs.
  always_comb begin
    clr_busy = (clr_state_q == StClear);
  end

  // A switch into a bank being cleared (or starting to clear this cycle) waits for the scrub.
  assign sw_blocked = ((clr_state_q == StClear) && (clr_idx_q == bank_sel_i)) ||
                      (clr_start && (bank_clr_idx_i == bank_sel_i));

  always_comb begin
    active_bank_d = active_bank_q;
    ack_d         = 1'b0;
    if (bank_switch_req_i) begin
      if (!sel_valid) begin
        ack_d = 1'b1;
      end else if (!sw_blocked) begin
        ack_d         = 1'b1;
        active_bank_d = bank_sel_i;
      end
    end
  end

  assign err_d = we_bad || clr_err || (bank_switch_req_i && !sel_valid);

  // Port write and clear step never hit the same bank since clearing the active bank is refused.
  always_comb begin
    mem_d = mem_q;
    if (we_valid) begin
      mem_d[active_bank_q][waddr] = wdata_a_i;
    end
    if (clr_busy) begin
      mem_d[clr_idx_q][clr_cnt_q] = WordZeroVal;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned b = 0; b < NumBanks; b++) begin
        for (int unsigned w = 1; w < NumWords; w++) begin
          mem_q[b][w] <= WordZeroVal;
        end
      end
      active_bank_q <= '0;
      ack_q         <= 1'b0;
      err_q         <= 1'b0;
      clr_state_q   <= StIdle;
      clr_idx_q     <= '0;
      clr_cnt_q     <= '0;
    end else begin
      mem_q         <= mem_d;
      active_bank_q <= active_bank_d;
      ack_q         <= ack_d;
      err_q         <= err_d;
      clr_state_q   <= clr_state_d;
      clr_idx_q     <= clr_idx_d;
      clr_cnt_q     <= clr_cnt_d;
    end
  end

  for (genvar p = 0; p < NumReadPorts; p++) begin : g_rd
    logic [AddrW-1:0]     ra;
    logic [DataWidth-1:0] stored;
    assign ra     = raddr_i[5*p +: AddrW];
    assign stored = (ra == '0) ? WordZeroVal : mem_q[active_bank_q][ra];
    assign rdata_o[DataWidth*p +: DataWidth] =
        (WriteBypass && we_valid && (waddr == ra)) ? wdata_a_i : stored;
  end

  assign bank_switch_ack_o = ack_q;
  assign active_bank_o     = active_bank_q;
  assign bank_clr_busy_o   = clr_busy;
  assign err_o             = err_q;

endmodule

// File: tb/tb_ibex_register_file_banked.sv
// Directed bench: dut0 is a 3-bank RV32I file with bypass, dut1 a 2-bank RV32E file without.
module tb_ibex_register_file_banked;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  always #5 clk_i = ~clk_i;

  // dut0 signals
  logic [9:0]  raddr0 = '0;
  logic [63:0] rdata0;
  logic [4:0]  waddr0 = '0;
  logic [31:0] wdata0 = '0;
  logic        we0 = 1'b0, sw_req0 = 1'b0, clr_req0 = 1'b0;
  logic [1:0]  sel0 = '0, clr_idx0 = '0, act0;
  logic        ack0, busy0, err0;

  // dut1 signals
  logic [14:0] raddr1 = '0;
  logic [95:0] rdata1;
  logic [4:0]  waddr1 = '0;
  logic [31:0] wdata1 = '0;
  logic        we1 = 1'b0, sw_req1 = 1'b0, clr_req1 = 1'b0;
  logic [0:0]  sel1 = '0, clr_idx1 = '0, act1;
  logic        ack1, busy1, err1;

  int n_checks = 0;
  int n_pass   = 0;

  ibex_register_file_banked #(
    .RV32E(1'b0), .DataWidth(32), .NumBanks(3), .NumReadPorts(2), .WriteBypass(1'b1),
    .WordZeroVal('0)
  ) dut0 (
    .clk_i(clk_i), .rst_i(rst_i), .raddr_i(raddr0), .rdata_o(rdata0),
    .waddr_a_i(waddr0), .wdata_a_i(wdata0), .we_a_i(we0),
    .bank_switch_req_i(sw_req0), .bank_sel_i(sel0), .bank_switch_ack_o(ack0),
    .active_bank_o(act0), .bank_clr_req_i(clr_req0), .bank_clr_idx_i(clr_idx0),
    .bank_clr_busy_o(busy0), .err_o(err0)
  );

  ibex_register_file_banked #(
    .RV32E(1'b1), .DataWidth(32), .NumBanks(2), .NumReadPorts(3), .WriteBypass(1'b0),
    .WordZeroVal('0)
  ) dut1 (
    .clk_i(clk_i), .rst_i(rst_i), .raddr_i(raddr1), .rdata_o(rdata1),
    .waddr_a_i(waddr1), .wdata_a_i(wdata1), .we_a_i(we1),
    .bank_switch_req_i(sw_req1), .bank_sel_i(sel1), .bank_switch_ack_o(ack1),
    .active_bank_o(act1), .bank_clr_req_i(clr_req1), .bank_clr_idx_i(clr_idx1),
    .bank_clr_busy_o(busy1), .err_o(err1)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Inputs change 2 time units after each rising edge.
  task automatic cyc();
    @(posedge clk_i);
    #2;
  endtask

  task automatic wr0(input logic [4:0] a, input logic [31:0] d);
    we0 = 1'b1; waddr0 = a; wdata0 = d;
    cyc();
    we0 = 1'b0;
  endtask

  task automatic wr1(input logic [4:0] a, input logic [31:0] d);
    we1 = 1'b1; waddr1 = a; wdata1 = d;
    cyc();
    we1 = 1'b0;
  endtask

  task automatic sw0(input logic [1:0] b);
    sw_req0 = 1'b1; sel0 = b;
    cyc();
    sw_req0 = 1'b0;
  endtask

  task automatic sw1(input logic [0:0] b);
    sw_req1 = 1'b1; sel1 = b;
    cyc();
    sw_req1 = 1'b0;
  endtask

  task automatic wait_idle0();
    int n = 0;
    while (busy0 && n < 100) begin
      n++;
      cyc();
    end
    check("clr_timeout", busy0, 1'b0);
  endtask

  initial begin
    int  busy_cycles;
    bit  ack_seen;
    repeat (2) cyc();
    rst_i = 1'b0;
    cyc();

    // Reset state
    check("rst_act", act0, 2'd0);
    check("rst_ack", ack0, 1'b0);
    check("rst_busy", busy0, 1'b0);
    check("rst_err", err0, 1'b0);
    check("rst_act1", act1, 1'd0);
    for (int a = 0; a < 32; a++) begin
      raddr0 = {a[4:0], a[4:0]};
      #1;
      check("rst_rd", rdata0, 64'h0);
      cyc();
    end

    // R0 is hardwired, also not bypassed
    raddr0 = 10'd0;
    we0 = 1'b1; waddr0 = 5'd0; wdata0 = 32'hDEAD;
    #1;
    check("r0_bypass", rdata0[31:0], 32'h0);
    cyc();
    we0 = 1'b0;
    #1;
    check("r0_read", rdata0[31:0], 32'h0);

    // Bank switch round trip
    wr0(5'd5, 32'h1234_5678);
    raddr0 = {5'd0, 5'd5};
    #1;
    check("r5_b0", rdata0[31:0], 32'h1234_5678);
    sw0(2'd1);
    #1;
    check("sw1_ack", ack0, 1'b1);
    check("sw1_act", act0, 2'd1);
    check("r5_b1", rdata0[31:0], 32'h0);
    cyc();
    check("sw1_ack_drop", ack0, 1'b0);
    sw0(2'd0);
    #1;
    check("sw0_ack", ack0, 1'b1);
    check("r5_back", rdata0[31:0], 32'h1234_5678);
    cyc();

    // Same-cycle bypass on dut0, stored value on dut1
    we0 = 1'b1; waddr0 = 5'd7; wdata0 = 32'hA5A5_A5A5; raddr0 = {5'd7, 5'd5};
    #1;
    check("byp_p1", rdata0[63:32], 32'hA5A5_A5A5);
    check("byp_p0", rdata0[31:0], 32'h1234_5678);
    cyc();
    we0 = 1'b0;
    wr1(5'd7, 32'h0000_1111);
    we1 = 1'b1; waddr1 = 5'd7; wdata1 = 32'hA5A5_A5A5; raddr1 = {5'd0, 5'd7, 5'd0};
    #1;
    check("nobyp_p1", rdata1[63:32], 32'h0000_1111);
    cyc();
    we1 = 1'b0;
    #1;
    check("nobyp_after", rdata1[63:32], 32'hA5A5_A5A5);
    cyc();

    // Fill bank 1, then clear it from bank 0 with a switch-to-1 pending mid-clear
    sw0(2'd1);
    for (int a = 1; a < 32; a++) wr0(a[4:0], 32'h100 + a);
    raddr0 = {5'd0, 5'd31};
    #1;
    check("fill_r31", rdata0[31:0], 32'h11F);
    sw0(2'd0);
    clr_req0 = 1'b1; clr_idx0 = 2'd1;
    cyc();
    clr_req0 = 1'b0;
    busy_cycles = 0;
    ack_seen = 1'b0;
    while (busy0 && busy_cycles < 100) begin
      if (busy_cycles == 10) begin
        sw_req0 = 1'b1; sel0 = 2'd1;
      end
      if (ack0) ack_seen = 1'b1;
      busy_cycles++;
      cyc();
    end
    check("clr_busy_len", busy_cycles, 31);
    check("clr_no_early_ack", ack_seen, 1'b0);
    check("clr_end_ack", ack0, 1'b0);
    check("clr_end_act", act0, 2'd0);
    cyc();
    #1;
    check("defer_ack", ack0, 1'b1);
    check("defer_act", act0, 2'd1);
    sw_req0 = 1'b0;
    cyc();
    for (int a = 0; a < 32; a++) begin
      raddr0 = {a[4:0], a[4:0]};
      #1;
      check("clr_rd", rdata0, 64'h0);
      cyc();
    end

    // Error cases (active bank is 1)
    wr0(5'd9, 32'h99);
    clr_req0 = 1'b1; clr_idx0 = 2'd1;
    cyc();
    clr_req0 = 1'b0;
    check("err_clr_active", err0, 1'b1);
    check("busy_clr_active", busy0, 1'b0);
    cyc();
    check("err_pulse1", err0, 1'b0);
    cyc();
    raddr0 = {5'd0, 5'd9};
    #1;
    check("r9_kept", rdata0[31:0], 32'h99);
    clr_req0 = 1'b1; clr_idx0 = 2'd3;
    cyc();
    clr_req0 = 1'b0;
    check("err_clr_idx", err0, 1'b1);
    check("busy_clr_idx", busy0, 1'b0);
    sw0(2'd3);
    check("err_sel3", err0, 1'b1);
    check("ack_sel3", ack0, 1'b1);
    check("act_sel3", act0, 2'd1);
    cyc();
    check("err_pulse2", err0, 1'b0);
    clr_req0 = 1'b1; clr_idx0 = 2'd0;
    cyc();
    clr_req0 = 1'b0;
    check("clr_b0_busy", busy0, 1'b1);
    check("clr_b0_err", err0, 1'b0);
    clr_req0 = 1'b1; clr_idx0 = 2'd2;
    cyc();
    clr_req0 = 1'b0;
    check("err_clr_busy", err0, 1'b1);
    cyc();
    check("err_pulse3", err0, 1'b0);
    wait_idle0();

    // RV32E: address with bit 4 set is dropped
    wr1(5'h13, 32'hBAD);
    check("e_err", err1, 1'b1);
    raddr1 = {5'd15, 5'h13, 5'd3};
    #1;
    check("e_r3", rdata1[31:0], 32'h0);
    check("e_r13", rdata1[63:32], 32'h0);
    cyc();
    check("e_err_pulse", err1, 1'b0);
    wr1(5'd15, 32'hF);
    #1;
    check("e_r15_p2", rdata1[95:64], 32'hF);

    // Reset mid-clear on dut1
    sw1(1'b1);
    wr1(5'd14, 32'h44);
    sw1(1'b0);
    clr_req1 = 1'b1; clr_idx1 = 1'b1;
    cyc();
    clr_req1 = 1'b0;
    check("e_clr_busy", busy1, 1'b1);
    repeat (3) cyc();
    rst_i = 1'b1;
    cyc();
    rst_i = 1'b0;
    check("rst_mid_busy", busy1, 1'b0);
    check("rst_mid_act0", act0, 2'd0);
    raddr1 = {5'd15, 5'd7, 5'd0};
    #1;
    check("rst_mid_r7", rdata1[63:32], 32'h0);
    check("rst_mid_r15", rdata1[95:64], 32'h0);
    sw1(1'b1);
    raddr1 = {5'd0, 5'd0, 5'd14};
    #1;
    check("rst_mid_r14", rdata1[31:0], 32'h0);
    check("rst_mid_busy2", busy1, 1'b0);
    sw0(2'd1);
    raddr0 = {5'd0, 5'd9};
    #1;
    check("rst_r9", rdata0[31:0], 32'h0);
    cyc();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
